mix_vga_agc: RTL and testbench

Automatic gain controller for the mixer-stage variable-gain amplifier. It watches the post-mixer magnitude stream, measures the peak over fixed windows, and steps the 3-bit VGA gain level up or down with settle blanking after each change. A host manual override is also supported. Its `vga_level` output feeds the mixer VGA thermometer decoder directly: level N enables N of the 6 gain stages.

---
 rtl/mix_vga_agc_if.sv | 27 ++
 rtl/mix_vga_agc.sv | 152 +++++++++++++++
 tb/tb_mix_vga_agc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mix_vga_agc_if.sv
// Sample/threshold/override bus into the mixer VGA gain controller and its gain-level outputs.
interface mix_vga_agc_if #(
  parameter int LEVEL_WIDTH = 3,
  parameter int MAG_WIDTH   = 12
);
  logic                   sample_valid;
  logic [MAG_WIDTH-1:0]   sample_mag;
  logic [MAG_WIDTH-1:0]   thr_hi;
  logic [MAG_WIDTH-1:0]   thr_lo;
  logic                   manual_en;
  logic [LEVEL_WIDTH-1:0] manual_level;
  logic [LEVEL_WIDTH-1:0] vga_level;
  logic                   level_changed;
  logic                   at_min;
  logic                   at_max;
  logic [1:0]             agc_state;

  modport master (
    output sample_valid, sample_mag, thr_hi, thr_lo, manual_en, manual_level,
    input  vga_level, level_changed, at_min, at_max, agc_state
  );

  modport slave (
    input  sample_valid, sample_mag, thr_hi, thr_lo, manual_en, manual_level,
    output vga_level, level_changed, at_min, at_max, agc_state
  );
endinterface

// File: rtl/mix_vga_agc.sv
// Peak-window AGC stepping the mixer VGA level with settle blanking and host override.
// Optional build macro: MIX_VGA_AGC_FAST_ATTACK_EN (full-scale peak drops the level by 2).
module mix_vga_agc #(
  parameter int LEVEL_WIDTH   = 3,
  parameter int MAX_LEVEL     = 6,
  parameter int RESET_LEVEL   = 3,
  parameter int MAG_WIDTH     = 12,
  parameter int WINDOW        = 64,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  mix_vga_agc_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ADJUST  = 2'd2,
    ST_MANUAL  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [LEVEL_WIDTH-1:0] MAX_LVL  = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0] RST_LVL  = LEVEL_WIDTH'(RESET_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0] LVL_ZERO = {LEVEL_WIDTH{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [SET_W-1:0]       SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                 state_r;
  logic [SET_W-1:0]       settle_cnt_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [MAG_WIDTH-1:0]   peak_r;
  logic [LEVEL_WIDTH-1:0] level_r;
  logic                   level_changed_r;
  logic                   at_min_r;
  logic                   at_max_r;
  logic [LEVEL_WIDTH-1:0] lvl_nxt_s;

  function automatic logic [LEVEL_WIDTH-1:0] clamp_level(input logic [LEVEL_WIDTH-1:0] req);
    logic [LEVEL_WIDTH-1:0] res;
    if (req > MAX_LVL) res = MAX_LVL;
    else               res = req;
    return res;
  endfunction

  // High threshold is tested first so it wins when the thresholds are crossed.
  function automatic logic [LEVEL_WIDTH-1:0] adjust_level(
    input logic [LEVEL_WIDTH-1:0] lvl,
    input logic [MAG_WIDTH-1:0]   peak,
    input logic [MAG_WIDTH-1:0]   hi,
    input logic [MAG_WIDTH-1:0]   lo
  );
    logic [LEVEL_WIDTH-1:0] res;
    res = lvl;
`ifdef MIX_VGA_AGC_FAST_ATTACK_EN
    if ((peak == {MAG_WIDTH{1'b1}}) && (lvl != LVL_ZERO)) begin
      if (lvl >= LEVEL_WIDTH'(2)) res = lvl - LEVEL_WIDTH'(2);
      else                        res = LVL_ZERO;
    end else
`endif
    if ((peak > hi) && (lvl != LVL_ZERO)) res = lvl - LEVEL_WIDTH'(1);
    else if ((peak < lo) && (lvl < MAX_LVL)) res = lvl + LEVEL_WIDTH'(1);
    else res = lvl;
    return res;
  endfunction

  // Next gain level: manual follow, window adjust, or hold.
  always_comb begin
    lvl_nxt_s = level_r;
    if (bus.manual_en) begin
      if (state_r == ST_MANUAL) lvl_nxt_s = clamp_level(bus.manual_level);
      else                      lvl_nxt_s = level_r;
    end else if (state_r == ST_ADJUST) begin
      lvl_nxt_s = adjust_level(level_r, peak_r, bus.thr_hi, bus.thr_lo);
    end else begin
      lvl_nxt_s = level_r;
    end
  end

  // Control FSM with registered level and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= ST_SETTLE;
      settle_cnt_r    <= {SET_W{1'b0}};
      cnt_r           <= {CNT_W{1'b0}};
      peak_r          <= {MAG_WIDTH{1'b0}};
      level_r         <= RST_LVL;
      level_changed_r <= 1'b0;
      at_min_r        <= (RST_LVL == LVL_ZERO);
      at_max_r        <= (RST_LVL == MAX_LVL);
    end else begin
      level_r         <= lvl_nxt_s;
      level_changed_r <= (lvl_nxt_s != level_r);
      at_min_r        <= (lvl_nxt_s == LVL_ZERO);
      at_max_r        <= (lvl_nxt_s == MAX_LVL);
      if (bus.manual_en) begin
        state_r <= ST_MANUAL;
      end else begin
        case (state_r)
          ST_SETTLE: begin
            if (settle_cnt_r == SET_LAST) begin
              state_r      <= ST_MEASURE;
              settle_cnt_r <= {SET_W{1'b0}};
              peak_r       <= {MAG_WIDTH{1'b0}};
              cnt_r        <= {CNT_W{1'b0}};
            end else begin
              settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end
          end
          ST_MEASURE: begin
            if (bus.sample_valid) begin
              if (bus.sample_mag > peak_r) peak_r <= bus.sample_mag;
              else                         peak_r <= peak_r;
              cnt_r <= cnt_r + CNT_W'(1);
              if (cnt_r == CNT_LAST) state_r <= ST_ADJUST;
              else                   state_r <= ST_MEASURE;
            end else begin
              state_r <= ST_MEASURE;
            end
          end
          ST_ADJUST: begin
            if (lvl_nxt_s != level_r) begin
              state_r      <= ST_SETTLE;
              settle_cnt_r <= {SET_W{1'b0}};
            end else begin
              state_r <= ST_MEASURE;
              peak_r  <= {MAG_WIDTH{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
          ST_MANUAL: begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SET_W{1'b0}};
          end
          default: begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SET_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign bus.vga_level     = level_r;
  assign bus.level_changed = level_changed_r;
  assign bus.at_min        = at_min_r;
  assign bus.at_max        = at_max_r;
  assign bus.agc_state     = state_r;

endmodule

// File: tb/tb_mix_vga_agc.sv
// Scoreboard bench for mix_vga_agc: expected level changes are queued at stimulus time and
// popped by a monitor on every level_changed pulse; directed checks cover state timing.
module tb_mix_vga_agc;

  logic clk;
  logic rst;

  mix_vga_agc_if #(.LEVEL_WIDTH(3), .MAG_WIDTH(12)) bus();

  mix_vga_agc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int lvl;
    int mn;
    int mx;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   lv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int l);
    exp_t e;
    e.lvl = l;
    e.mn  = (l == 0) ? 1 : 0;
    e.mx  = (l == 6) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_measure();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!seen && bus.agc_state == 2'd1) seen = 1'b1;
      if (!seen) tick();
    end
    if (!seen) chk("wait_measure_timeout", 0, 1);
  endtask

  task automatic send(input int mag, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_mag   = 12'(mag);
      tick();
    end
    bus.sample_valid = 1'b0;
  endtask

  // Monitor: every level_changed pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && bus.level_changed) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_level_change", int'(bus.vga_level), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_level",  int'(bus.vga_level), e.lvl);
        chk("sb_at_min", int'(bus.at_min),    e.mn);
        chk("sb_at_max", int'(bus.at_max),    e.mx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_mag   = 12'd0;
    bus.thr_lo       = 12'd100;
    bus.thr_hi       = 12'd2000;
    bus.manual_en    = 1'b0;
    bus.manual_level = 3'd0;

    // reset state and settle length
    tick(); tick();
    chk("rst_level",   int'(bus.vga_level), 3);
    chk("rst_changed", int'(bus.level_changed), 0);
    chk("rst_state",   int'(bus.agc_state), 0);
    chk("rst_at_min",  int'(bus.at_min), 0);
    chk("rst_at_max",  int'(bus.at_max), 0);
    rst = 1'b1;
    repeat (15) tick();
    chk("settle_15", int'(bus.agc_state), 0);
    tick();
    chk("settle_16", int'(bus.agc_state), 1);

    // low signal: 3 -> 4 -> 5 -> 6, then hold
    for (int l = 4; l <= 6; l++) begin
      wait_measure();
      push_exp(l);
      send(50, 64);
      tick();
      chk("low_step", int'(bus.vga_level), l);
    end
    wait_measure();
    send(50, 64);
    chk("low_hold_adjust", int'(bus.agc_state), 2);
    tick();
    chk("low_hold_state", int'(bus.agc_state), 1);
    chk("low_hold_level", int'(bus.vga_level), 6);
    chk("low_hold_at_max", int'(bus.at_max), 1);

    // high signal: 6 -> 0, then hold without wrap
    for (int l = 5; l >= 0; l--) begin
      wait_measure();
      push_exp(l);
      send(3000, 64);
      tick();
      chk("high_step", int'(bus.vga_level), l);
    end
    wait_measure();
    send(3000, 64);
    tick();
    chk("high_hold_level", int'(bus.vga_level), 0);
    chk("high_hold_at_min", int'(bus.at_min), 1);
    chk("high_hold_state", int'(bus.agc_state), 1);

    // manual override with clamp, then release into settle
    push_exp(6);
    bus.manual_en    = 1'b1;
    bus.manual_level = 3'd7;
    tick();
    chk("man_state", int'(bus.agc_state), 3);
    chk("man_level_prev", int'(bus.vga_level), 0);
    tick();
    chk("man_clamp", int'(bus.vga_level), 6);
    push_exp(5);
    bus.manual_level = 3'd5;
    tick();
    chk("man_follow", int'(bus.vga_level), 5);
    bus.manual_en = 1'b0;
    tick();
    chk("man_rel_state", int'(bus.agc_state), 0);
    repeat (15) tick();
    chk("man_settle_15", int'(bus.agc_state), 0);
    tick();
    chk("man_settle_16", int'(bus.agc_state), 1);
    chk("man_level_held", int'(bus.vga_level), 5);

    // full-scale single sample
`ifdef MIX_VGA_AGC_FAST_ATTACK_EN
    lv = 3;
`else
    lv = 4;
`endif
    push_exp(lv);
    send(4095, 1);
    send(1000, 63);
    tick();
    chk("full_scale", int'(bus.vga_level), lv);

    // crossed thresholds: high threshold wins
    bus.thr_lo = 12'd3000;
    bus.thr_hi = 12'd500;
    wait_measure();
    push_exp(lv - 1);
    send(1000, 64);
    tick();
    chk("crossed_thr", int'(bus.vga_level), lv - 1);

    // peak equal to both thresholds: in band, ADJUST then MEASURE
    bus.thr_lo = 12'd1000;
    bus.thr_hi = 12'd1000;
    wait_measure();
    send(1000, 64);
    chk("inband_adjust", int'(bus.agc_state), 2);
    tick();
    chk("inband_measure", int'(bus.agc_state), 1);
    chk("inband_level", int'(bus.vga_level), lv - 1);

    // reset mid-window discards the partial high peak
    bus.thr_lo = 12'd100;
    bus.thr_hi = 12'd2000;
    send(3000, 32);
    rst = 1'b0;
    tick();
    chk("mid_rst_level", int'(bus.vga_level), 3);
    chk("mid_rst_state", int'(bus.agc_state), 0);
    rst = 1'b1;
    wait_measure();
    send(1000, 64);
    tick();
    chk("mid_rst_keep", int'(bus.vga_level), 3);
    chk("mid_rst_state2", int'(bus.agc_state), 1);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
